// File: rtl/psram_cmd_queue_if.sv
// Command/response bundle between the user, psram_cmd_queue and the async PSRAM controller.
// The slave modport is the queue's view; master is the user/controller side.
interface psram_cmd_queue_if #(
    parameter int DEPTH_LOG = 3
);
    logic                 CMD_VALID;
    logic                 CMD_WE;
    logic [22:0]          CMD_ADDR;
    logic [15:0]          CMD_DATA;
    logic                 CMD_READY;
    logic [DEPTH_LOG:0]   COUNT;
    logic                 W_REQ;
    logic                 R_REQ;
    logic [22:0]          WADDR;
    logic [22:0]          RADDR;
    logic [15:0]          D_IN;
    logic                 BUSY;
    logic [15:0]          RDOUT;
    logic                 RDOUT_EN;
    logic [15:0]          RDATA;
    logic                 RVALID;
    logic                 ERR;

    modport slave (
        input  CMD_VALID, CMD_WE, CMD_ADDR, CMD_DATA, BUSY, RDOUT, RDOUT_EN,
        output CMD_READY, COUNT, W_REQ, R_REQ, WADDR, RADDR, D_IN, RDATA, RVALID, ERR
    );

    modport master (
        output CMD_VALID, CMD_WE, CMD_ADDR, CMD_DATA, BUSY, RDOUT, RDOUT_EN,
        input  CMD_READY, COUNT, W_REQ, R_REQ, WADDR, RADDR, D_IN, RDATA, RVALID, ERR
    );
endinterface

// File: rtl/psram_cmd_queue.sv
// In-order command FIFO feeding a single-outstanding async PSRAM controller, plus read-data return.
// Optional sticky overflow flag: define PSRAMQ_OVF_ERR_EN to enable ERR detection.
module psram_cmd_queue #(
    parameter int DEPTH_LOG = 3
) (
    input  logic                CLK,
    input  logic                RST,
    psram_cmd_queue_if.slave    bus
);
    localparam int DEPTH = 1 << DEPTH_LOG;

    typedef struct packed {
        logic        we;
        logic [22:0] addr;
        logic [15:0] data;
    } entry_t;

    entry_t                 mem [DEPTH];
    entry_t                 head;
    logic [DEPTH_LOG-1:0]   wr_ptr;
    logic [DEPTH_LOG-1:0]   rd_ptr;
    logic [DEPTH_LOG:0]     count;
    logic                   w_req_q;
    logic                   r_req_q;
    logic [22:0]            waddr_q;
    logic [22:0]            raddr_q;
    logic [15:0]            d_in_q;
    logic [15:0]            rdata_q;
    logic                   rvalid_q;
    logic                   push;
    logic                   pop;

    assign bus.CMD_READY = (count < (DEPTH_LOG+1)'(DEPTH));
    assign push          = bus.CMD_VALID && bus.CMD_READY;
    // A request pulse blocks the next issue so the controller has a cycle to raise BUSY.
    assign pop           = (count != '0) && !bus.BUSY && !w_req_q && !r_req_q;
    assign head          = mem[rd_ptr];

    // NOTE: storage array has no reset; pointers and count alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= '{we: bus.CMD_WE, addr: bus.CMD_ADDR, data: bus.CMD_DATA};
        end
    end

    // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            w_req_q  <= 1'b0;
            r_req_q  <= 1'b0;
            waddr_q  <= '0;
            raddr_q  <= '0;
            d_in_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            w_req_q <= pop && head.we;
            r_req_q <= pop && !head.we;
            if (pop) begin
                if (head.we) begin
                    waddr_q <= head.addr;
                    d_in_q  <= head.data;
                    raddr_q <= '0;
                end else begin
                    raddr_q <= head.addr;
                    waddr_q <= '0;
                end
            end

            rvalid_q <= bus.RDOUT_EN;
            if (bus.RDOUT_EN) rdata_q <= bus.RDOUT;
        end
    end

    assign bus.COUNT  = count;
    assign bus.W_REQ  = w_req_q;
    assign bus.R_REQ  = r_req_q;
    assign bus.WADDR  = waddr_q;
    assign bus.RADDR  = raddr_q;
    assign bus.D_IN   = d_in_q;
    assign bus.RDATA  = rdata_q;
    assign bus.RVALID = rvalid_q;

`ifdef PSRAMQ_OVF_ERR_EN
    logic err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (bus.CMD_VALID && !bus.CMD_READY) begin
            err_q <= 1'b1;
        end
    end

    assign bus.ERR = err_q;
`else
    assign bus.ERR = 1'b0;
`endif

endmodule

// File: tb/tb_psram_cmd_queue.sv
// Directed self-checking bench for psram_cmd_queue with a simple BUSY controller model.
module tb_psram_cmd_queue;
    localparam int DEPTH_LOG = 3;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    psram_cmd_queue_if #(.DEPTH_LOG(DEPTH_LOG)) bus ();

    psram_cmd_queue #(.DEPTH_LOG(DEPTH_LOG)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic        we;
        logic [22:0] addr;
        logic [15:0] data;
        int          cyc;
    } req_t;

    req_t log_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_req = -100;
    int   busy_cnt = 0;
    logic ctrl_en = 1'b0;
    logic busy_force = 1'b0;

`ifdef PSRAMQ_OVF_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    assign bus.BUSY = busy_force | (busy_cnt != 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_cmd(input logic we, input logic [22:0] a, input logic [15:0] d);
        bus.CMD_VALID = 1'b1;
        bus.CMD_WE    = we;
        bus.CMD_ADDR  = a;
        bus.CMD_DATA  = d;
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("log_wait", log_q.size() >= n, 1);
    endtask

    // Request monitor and controller model: a request holds BUSY for 8 cycles when enabled.
    always @(negedge CLK) begin
        cyc++;
        if (busy_cnt > 0) busy_cnt--;
        if (bus.W_REQ || bus.R_REQ) begin
            check("one_req", bus.W_REQ & bus.R_REQ, 0);
            check("req_gap", (cyc - last_req) >= 2, 1);
            last_req = cyc;
            log_q.push_back('{we: bus.W_REQ, addr: (bus.W_REQ ? bus.WADDR : bus.RADDR),
                              data: bus.D_IN, cyc: cyc});
            if (ctrl_en) busy_cnt = 8;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST          = 1'b1;
        bus.CMD_VALID = 1'b0;
        bus.CMD_WE    = 1'b0;
        bus.CMD_ADDR  = '0;
        bus.CMD_DATA  = '0;
        bus.RDOUT     = '0;
        bus.RDOUT_EN  = 1'b0;
        repeat (2) tick();
        RST = 1'b0;

        check("rst_count",  bus.COUNT, 0);
        check("rst_ready",  bus.CMD_READY, 1);
        check("rst_wreq",   bus.W_REQ, 0);
        check("rst_rreq",   bus.R_REQ, 0);
        check("rst_rvalid", bus.RVALID, 0);
        check("rst_err",    bus.ERR, 0);
        check("rst_waddr",  bus.WADDR, 0);
        check("rst_raddr",  bus.RADDR, 0);
        check("rst_din",    bus.D_IN, 0);
        check("rst_rdata",  bus.RDATA, 0);

        // Single write: push edge, issue on the following edge.
        push_cmd(1'b1, 23'h000010, 16'hA5A5);
        tick();
        bus.CMD_VALID = 1'b0;
        check("w1_count_push", bus.COUNT, 1);
        check("w1_wreq_early", bus.W_REQ, 0);
        tick();
        check("w1_wreq",  bus.W_REQ, 1);
        check("w1_waddr", bus.WADDR, 23'h000010);
        check("w1_din",   bus.D_IN, 16'hA5A5);
        check("w1_raddr", bus.RADDR, 0);
        check("w1_count", bus.COUNT, 0);
        tick();
        check("w1_wreq_end", bus.W_REQ, 0);
        check("w1_waddr_hold", bus.WADDR, 23'h000010);

        // Push on the same edge as a pop keeps COUNT steady.
        push_cmd(1'b0, 23'h000022, 16'h0000);
        tick();
        push_cmd(1'b1, 23'h000033, 16'h3333);
        tick();
        bus.CMD_VALID = 1'b0;
        check("se_count", bus.COUNT, 1);
        check("se_rreq",  bus.R_REQ, 1);
        check("se_raddr", bus.RADDR, 23'h000022);
        check("se_waddr_zero", bus.WADDR, 0);
        tick();
        check("se_hold_off", bus.W_REQ | bus.R_REQ, 0);
        check("se_count_hold", bus.COUNT, 1);
        tick();
        check("se_wreq2",  bus.W_REQ, 1);
        check("se_waddr2", bus.WADDR, 23'h000033);
        check("se_raddr_zero", bus.RADDR, 0);
        check("se_count0", bus.COUNT, 0);
        tick();

        // Read data return: one-cycle pulse, value held afterwards.
        bus.RDOUT    = 16'h1234;
        bus.RDOUT_EN = 1'b1;
        tick();
        bus.RDOUT_EN = 1'b0;
        bus.RDOUT    = 16'hFFFF;
        check("rd_rvalid", bus.RVALID, 1);
        check("rd_rdata",  bus.RDATA, 16'h1234);
        tick();
        check("rd_rvalid_end", bus.RVALID, 0);
        check("rd_rdata_hold", bus.RDATA, 16'h1234);

        // Write then read of 0x5 against the BUSY model.
        ctrl_en = 1'b1;
        log_q.delete();
        push_cmd(1'b1, 23'h000005, 16'h5A5A);
        tick();
        push_cmd(1'b0, 23'h000005, 16'h0000);
        tick();
        bus.CMD_VALID = 1'b0;
        wait_log(2, 60);
        if (log_q.size() >= 2) begin
            check("ctl_first_we",   log_q[0].we, 1);
            check("ctl_first_addr", log_q[0].addr, 23'h000005);
            check("ctl_first_data", log_q[0].data, 16'h5A5A);
            check("ctl_second_we",  log_q[1].we, 0);
            check("ctl_second_addr", log_q[1].addr, 23'h000005);
            check("ctl_busy_gap", (log_q[1].cyc - log_q[0].cyc) >= 9, 1);
        end
        repeat (12) tick();
        ctrl_en = 1'b0;

        // Fill to capacity with BUSY held, then overflow attempt.
        busy_force = 1'b1;
        log_q.delete();
        for (int i = 0; i < 8; i++) begin
            push_cmd(i[0], 23'(i), 16'(i));
            check("fill_ready", bus.CMD_READY, 1);
            tick();
        end
        check("full_count", bus.COUNT, 8);
        check("full_ready", bus.CMD_READY, 0);
        push_cmd(1'b0, 23'h7FFFFF, 16'hDEAD);
        tick();
        check("ovf_count", bus.COUNT, 8);
        check("ovf_err",   bus.ERR, ERR_EXP);

        // Refill as entries drain; order must survive pointer wrap.
        busy_force = 1'b0;
        for (int k = 8; k < 16; k++) begin
            int w = 0;
            push_cmd(k[0], 23'(k), 16'(k));
            while (!bus.CMD_READY && w < 20) begin
                tick();
                w++;
            end
            tick();
            check("refill_count", bus.COUNT, 8);
        end
        bus.CMD_VALID = 1'b0;
        wait_log(16, 100);
        if (log_q.size() >= 16) begin
            for (int i = 0; i < 16; i++) begin
                check("order_addr", log_q[i].addr, 23'(i));
                check("order_we",   log_q[i].we, i[0]);
            end
        end
        repeat (3) tick();

        // Reset mid-operation with entries queued and a read request in flight.
        log_q.delete();
        busy_force = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_cmd(1'b0, 23'h000100 + 23'(i), 16'h0000);
            tick();
        end
        bus.CMD_VALID = 1'b0;
        busy_force = 1'b0;
        tick();
        busy_force = 1'b1;
        check("pre_rst_rreq",  bus.R_REQ, 1);
        check("pre_rst_count", bus.COUNT, 5);
        RST          = 1'b1;
        push_cmd(1'b1, 23'h000200, 16'h2222);
        bus.RDOUT    = 16'hBEEF;
        bus.RDOUT_EN = 1'b1;
        tick();
        check("mid_rst_count",  bus.COUNT, 0);
        check("mid_rst_rreq",   bus.R_REQ, 0);
        check("mid_rst_err",    bus.ERR, 0);
        check("mid_rst_rvalid", bus.RVALID, 0);
        check("mid_rst_raddr",  bus.RADDR, 0);
        check("mid_rst_ready",  bus.CMD_READY, 1);
        RST           = 1'b0;
        bus.CMD_VALID = 1'b0;
        bus.RDOUT_EN  = 1'b0;
        busy_force    = 1'b0;
        repeat (10) tick();
        check("post_rst_reqs",  log_q.size(), 1);
        check("post_rst_count", bus.COUNT, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
